// File: rtl/i2s_rx_sample_fifo.sv
// i2s_rx_sample_fifo: 512 x 32 receive-sample FIFO, I2S deserializer -> Wishbone register block, FWFT head word.
// Latency: a word pushed into an empty FIFO is visible on pop_dat_o one cycle later; a pop shows the next word one cycle later.
// Backpressure: none, both sides are strobes; a push when full is dropped (sticky overrun), a pop when empty is ignored (sticky underrun).
// Optional build macro I2S_RX_FIFO_THRESH_INT_EN enables the registered fill-threshold interrupt.
module i2s_rx_sample_fifo #(
  parameter int DATAWIDTH  = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int CNTWIDTH   = DEPTH_LOG2 + 1
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] push_dat_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic                 flag_clr_i,
  output logic [DATAWIDTH-1:0] pop_dat_o,
  output logic [CNTWIDTH-1:0]  fifo_cnt_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 fifo_ovrrun_o,
  output logic                 fifo_undrun_o,
  input  logic [CNTWIDTH-1:0]  thresh_i,
  output logic                 thresh_irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNTWIDTH-1:0] CNT_FULL = CNTWIDTH'(DEPTH);

  logic [DATAWIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [DATAWIDTH-1:0]  pop_dat_q, pop_dat_d;
  logic                  ovrrun_q, ovrrun_d;
  logic                  undrun_q, undrun_d;
  logic                  irq_q, irq_d;
  logic                  push_acc, pop_acc;
  logic                  ovr_evt, und_evt;

  // Acceptance decisions: flush overrides everything; a full FIFO still takes a push if a pop frees a slot.
  always_comb begin
    pop_acc  = pop_i && !empty_q && !flush_i;
    push_acc = push_i && !flush_i && (!full_q || pop_acc);
    ovr_evt  = push_i && !flush_i && full_q && !pop_acc;
    und_evt  = pop_i && !flush_i && empty_q;
  end

  assign rd_ptr_nxt = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Next-state for pointers, count, status and the FWFT head register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    pop_dat_d = pop_dat_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      if (pop_acc)  rd_ptr_d = rd_ptr_nxt;
      cnt_d = cnt_q + {{(CNTWIDTH-1){1'b0}}, push_acc} - {{(CNTWIDTH-1){1'b0}}, pop_acc};
      // Head word: bypass the incoming word when it becomes the head, else read the next stored entry.
      if (push_acc && empty_q) begin
        pop_dat_d = push_dat_i;
      end else if (pop_acc) begin
        if (cnt_q == {{(CNTWIDTH-1){1'b0}}, 1'b1}) begin
          if (push_acc) pop_dat_d = push_dat_i;
        end else begin
          pop_dat_d = mem_q[rd_ptr_nxt];
        end
      end
    end
    empty_d  = (cnt_d == '0);
    full_d   = (cnt_d == CNT_FULL);
    ovrrun_d = ovr_evt || (ovrrun_q && !flag_clr_i);
    undrun_d = und_evt || (undrun_q && !flag_clr_i);
  end

`ifdef I2S_RX_FIFO_THRESH_INT_EN
  // Level interrupt tracks the next-state count so it moves with fifo_cnt_o.
  always_comb begin
    irq_d = (thresh_i != '0) && (cnt_d >= thresh_i);
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  // Interrupt disabled in this build.
  always_comb begin
    irq_d = 1'b0;
  end
`endif

  // Sample storage; contents need no reset since pointers and count define validity.
  always_ff @(posedge WBs_CLK_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      pop_dat_q <= '0;
      ovrrun_q  <= 1'b0;
      undrun_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      pop_dat_q <= pop_dat_d;
      ovrrun_q  <= ovrrun_d;
      undrun_q  <= undrun_d;
      irq_q     <= irq_d;
    end
  end

  assign pop_dat_o     = pop_dat_q;
  assign fifo_cnt_o    = cnt_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign fifo_ovrrun_o = ovrrun_q;
  assign fifo_undrun_o = undrun_q;
  assign thresh_irq_o  = irq_q;

endmodule

// File: doc/i2s_rx_sample_fifo.md
Name: i2s_rx_sample_fifo

Overview:
- Receive-sample buffer between the I2S deserializer (push side) and the FPGA Wishbone register block (pop side).
- Stores 32-bit stereo sample words that arrive already synchronized to WBs_CLK_i.
- Presents the head word first-word-fall-through (FWFT) for register reads.
- Supplies the rx FIFO count and sticky overrun/underrun status that the register block exposes to the M4.

Parameters:
- DATAWIDTH, 32, sample word width.
- DEPTH_LOG2, 9, log2 of FIFO depth (512 entries).
- CNTWIDTH, DEPTH_LOG2+1 (10), width of count/threshold; holds 0..512 inclusive.

Ports:
- WBs_CLK_i  in  1  clock.
- WBs_RST_i  in  1  async reset, active-high.
- push_i  in  1  single-cycle write strobe from the I2S deserializer.
- push_dat_i  in  DATAWIDTH  sample word, valid with push_i.
- pop_i  in  1  single-cycle read-advance strobe from the register block (its Pop_Sig).
- flush_i  in  1  synchronous flush.
- flag_clr_i  in  1  clears sticky flags.
- pop_dat_o  out  DATAWIDTH  head word (FWFT).
- fifo_cnt_o  out  CNTWIDTH  words stored.
- empty_o  out  1  high when fifo_cnt_o==0.
- full_o  out  1  high when fifo_cnt_o==512.
- fifo_ovrrun_o  out  1  sticky: push dropped because the FIFO was full.
- fifo_undrun_o  out  1  sticky: pop requested while empty.
- thresh_i  in  CNTWIDTH  fill threshold (optional feature only).
- thresh_irq_o  out  1  level threshold interrupt (optional feature only).

Behaviour:
- Clocking/reset: all state on posedge WBs_CLK_i; async clear on WBs_RST_i.
- Reset values:
  - pointers = 0, fifo_cnt_o = 0
  - empty_o = 1, full_o = 0
  - pop_dat_o = 0
  - fifo_ovrrun_o = 0, fifo_undrun_o = 0
  - thresh_irq_o = 0
- Storage: DEPTH-entry memory; write pointer and read pointer are DEPTH_LOG2 bits and wrap 511->0 naturally.
- Count, empty_o and full_o are registered from the same next-state equations, so they are always mutually consistent.
- Push latency: a word pushed in cycle N is counted and visible on pop_dat_o in cycle N+1 when the FIFO was empty.
- Pop: pop_i with empty_o=0 advances the read pointer. pop_dat_o shows the next word, and fifo_cnt_o decrements, in the following cycle.
- pop_dat_o is held stable while empty_o=1 and while no pop occurs.
- Push when full_o=1 and no accepted pop:
  - word discarded, memory and pointers unchanged
  - fifo_ovrrun_o set next cycle
- Push and pop in the same cycle when full: both accepted; count stays 512; no overrun.
- Push and pop in the same cycle when empty:
  - push accepted, pop ignored, count becomes 1
  - fifo_undrun_o set
- Pop when empty without push: pointers unchanged, fifo_undrun_o set.
- Push and pop in the same cycle when 0 < count < 512: count unchanged, both pointers advance.
- flush_i:
  - next cycle: pointers = 0, count = 0, empty_o = 1
  - takes priority over a push or pop in the same cycle; that push is dropped without setting overrun
  - sticky flags are not affected
- flag_clr_i: clears both sticky flags next cycle. If a new overrun/underrun event occurs in the same cycle, set wins.
- Reset mid-stream: all contents are discarded immediately; no partial state survives.

Optional Feature:
- Macro I2S_RX_FIFO_THRESH_INT_EN.
- When defined:
  - thresh_irq_o is registered: 1 when the next-state count >= thresh_i and thresh_i != 0, else 0.
  - It updates in the same cycle as fifo_cnt_o.
  - thresh_i == 0 disables the interrupt.
- When undefined: thresh_i is unused and thresh_irq_o is tied to 0.

Test Plan:
- Reset, then push 0xA5A50001 once -> next cycle: pop_dat_o = 0xA5A50001, fifo_cnt_o = 1, empty_o = 0. Then pop once -> count 0, empty_o = 1, pop_dat_o holds 0xA5A50001.
- Push 512 incrementing words 0..511, then one extra push -> full_o = 1, count 512, fifo_ovrrun_o = 1. Pop all 512 -> data 0..511 in order; extra word absent.
- At full, push and pop in the same cycle for 600 cycles (exercises pointer wrap) -> count stays 512, no overrun, data order preserved.
- Empty FIFO: pop alone -> fifo_undrun_o = 1, pointers unchanged. flag_clr_i pulsed together with a second empty pop -> flag remains 1. Lone flag_clr_i -> 0.
- Count 37: assert flush_i together with push -> next cycle count 0, empty_o = 1, no overrun flag. Following push works normally.
- With I2S_RX_FIFO_THRESH_INT_EN and thresh_i = 8: the 8th push -> thresh_irq_o = 1 in the cycle count reads 8. One pop -> 0. With thresh_i = 0 -> stays 0.
